muxn_rr: RTL and testbench
==========================

Name: muxn_rr

Overview:
- Parametrised N-input, WIDTH-bit registered selector with valid/ready handshakes. Successor to the fixed 3:1 8-bit combinational mux.
- Two modes: fixed select (s port) and round-robin arbitration across valid inputs.
- Sits between producers (register file / ALU result buses) and a single consumer stage of the processor datapath.

Parameters:
- WIDTH, 8, data width of each channel and of y.
- N, 3, number of input channels (2..16).
- SELW, 2, select/index width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- d  input  N*WIDTH  flattened channel data; channel i at d[i*WIDTH +: WIDTH].
- d_valid  input  N  per-channel valid.
- d_ready  output  N  per-channel ready; combinational from grant and load enable.
- mode  input  1  0 = fixed select by s; 1 = round-robin.
- s  input  SELW  channel index in fixed mode; ignored in round-robin mode.
- y  output  WIDTH  registered selected data.
- y_sel  output  SELW  registered index of the channel held in y.
- y_valid  output  1  y/y_sel hold an unconsumed word.
- y_ready  input  1  consumer accepts y when y_valid & y_ready.

Behaviour:
- Reset values (synchronous, active-high; checked on clk rising edge): y=0, y_sel=0, y_valid=0, rr pointer ptr=N-1, so channel 0 has first priority.
- Output register: load_en = ~y_valid | y_ready.
- Grant, fixed mode: grant = onehot(s) & d_valid. If s >= N, no grant and no transfer.
- Grant, round-robin mode: first i with d_valid[i], searching ptr+1, ptr+2, … modulo N (wrap N-1 -> 0).
- d_ready[i] = grant[i] & load_en. At most one d_ready high per cycle. d_ready never depends on d_valid of other channels beyond grant computation.
- Transfer when load_en & (|grant): next cycle y=d[g], y_sel=g, y_valid=1.
- On transfer in round-robin mode: ptr <= g. In fixed mode ptr is unchanged.
- load_en & no grant: y_valid <= 0; y/y_sel retain their old values.
- ~load_en (y_valid & ~y_ready): y, y_sel, y_valid hold, and all d_ready=0 (stall).
- Latency: 1 cycle input-to-output. Full throughput: one word per cycle when y_ready is held high.
- Simultaneous consume and load: the word is replaced in the same edge; y_valid stays 1.
- Mode or s changes mid-stream take effect on the next grant evaluation. A held y is never altered.
- Reset asserted mid-transfer wins over any load: outputs go to reset values and the in-flight word is dropped.
- d_valid asserted with no grant: the producer must hold d and d_valid until d_ready.

Optional Feature:
- Macro MUXN_RR_PARITY_EN.
- When defined: extra output port y_par (1 bit), registered with y, equal to ^y of the loaded word. Reset value 0. Held under stall.
- When undefined: port y_par absent; no parity logic.

Decomposition:
- Package muxn_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function next_idx(idx, n) for the modulo-N wrap.
- Sub-module rr_arbiter (N, SELW): inputs req[N], ptr; outputs gnt_onehot[N], gnt_idx, any. Purely combinational; ptr state stays in muxn_rr.

Test Plan:
- Fixed mode, N=3, d0=8'h54, d1=8'h63, d2=8'h16, all valid, s=2, y_ready=1 -> one cycle later y=8'h16, y_sel=2, y_valid=1; d_ready=3'b100 each cycle.
- Fixed mode, s=3 (out of range), all valid -> d_ready=0, y_valid falls to 0 next cycle; y holds its last value.
- Round-robin, all valid continuously, y_ready=1 -> y_sel sequence 0,1,2,0,1 with y 8'h54, 8'h63, 8'h16, 8'h54, 8'h63.
- Round-robin, d_valid=3'b101 -> y_sel alternates 0,2,0,2; channel 1 never granted.
- Backpressure: y_valid=1, y_ready=0 for 3 cycles -> y, y_sel stable and d_ready=0. Release y_ready -> next word loads on the same edge the held word is consumed.
- Reset pulsed for 1 cycle mid-stream -> y=0, y_valid=0, next round-robin grant is channel 0. With MUXN_RR_PARITY_EN: y=8'h63 gives y_par=0, y=8'h54 gives y_par=1.

Source files
------------

// File: rtl/muxn_pkg.sv
//------------------------------------------------------------------------------
// muxn_pkg : shared mode encodings and index-wrap helper for muxn_rr.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muxn_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// rr_arbiter : combinational round-robin grant, searching from ptr+1 modulo N.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import muxn_pkg::*;
#(
  parameter int N    = 3,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [N-1:0]    gnt_onehot_o,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            any_o
);

  int w_cur;

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_o        = 1'b0;
    w_cur        = int'(ptr_i);
    for (int k = 0; k < N; k++) begin
      w_cur = next_idx(w_cur, N);
      if (!any_o && req_i[w_cur]) begin
        gnt_onehot_o[w_cur] = 1'b1;
        gnt_idx_o           = SELW'(w_cur);
        any_o               = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muxn_rr.sv
//------------------------------------------------------------------------------
// muxn_rr : N-input registered selector, fixed-select or round-robin, with
//           valid/ready handshakes. Define MUXN_RR_PARITY_EN to add y_par.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muxn_rr
  import muxn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic [N-1:0]       d_valid,
  output logic [N-1:0]       d_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    s,
  output logic [WIDTH-1:0]   y,
  output logic [SELW-1:0]    y_sel,
  output logic               y_valid,
  input  logic               y_ready
`ifdef MUXN_RR_PARITY_EN
  ,
  output logic               y_par
`endif
);

  localparam logic [SELW-1:0] C_PTR_RST = SELW'(N - 1);

  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  y_sel_q, y_sel_d;
  logic             y_valid_q, y_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             w_load_en;
  logic [N-1:0]     w_rr_gnt, w_fx_gnt, w_gnt;
  logic [SELW-1:0]  w_rr_idx, w_idx;
  logic             w_rr_any, w_any;

  assign w_load_en = ~y_valid_q | y_ready;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req_i        (d_valid),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (w_rr_gnt),
    .gnt_idx_o    (w_rr_idx),
    .any_o        (w_rr_any)
  );

  // An out-of-range s matches no channel, so it yields no grant.
  always_comb begin
    w_fx_gnt = '0;
    for (int i = 0; i < N; i++) begin
      w_fx_gnt[i] = d_valid[i] && (s == SELW'(i));
    end
  end

  assign w_gnt   = (mode == MODE_RR) ? w_rr_gnt : w_fx_gnt;
  assign w_idx   = (mode == MODE_RR) ? w_rr_idx : s;
  assign w_any   = |w_gnt;
  assign d_ready = w_load_en ? w_gnt : '0;

  always_comb begin
    y_d       = y_q;
    y_sel_d   = y_sel_q;
    y_valid_d = y_valid_q;
    ptr_d     = ptr_q;
    if (w_load_en) begin
      if (w_any) begin
        y_d       = d[int'(w_idx)*WIDTH +: WIDTH];
        y_sel_d   = w_idx;
        y_valid_d = 1'b1;
        if (mode == MODE_RR) begin
          ptr_d = w_idx;
        end
      end else begin
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q       <= '0;
      y_sel_q   <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= C_PTR_RST;
    end else begin
      y_q       <= y_d;
      y_sel_q   <= y_sel_d;
      y_valid_q <= y_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_sel   = y_sel_q;
  assign y_valid = y_valid_q;

`ifdef MUXN_RR_PARITY_EN
  logic y_par_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_par_q <= 1'b0;
    end else if (w_load_en && w_any) begin
      y_par_q <= ^y_d;
    end
  end

  assign y_par = y_par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_muxn_rr.sv
//------------------------------------------------------------------------------
// tb_muxn_rr : self-checking bench for muxn_rr against a behavioural model.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muxn_rr;

  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N*WIDTH-1:0] d;
  logic [N-1:0]       d_valid;
  logic [N-1:0]       d_ready;
  logic               mode;
  logic [SELW-1:0]    s;
  logic [WIDTH-1:0]   y;
  logic [SELW-1:0]    y_sel;
  logic               y_valid;
  logic               y_ready;
`ifdef MUXN_RR_PARITY_EN
  logic               y_par;
`endif

  muxn_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk     (clk),
    .reset   (reset),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .mode    (mode),
    .s       (s),
    .y       (y),
    .y_sel   (y_sel),
    .y_valid (y_valid),
    .y_ready (y_ready)
`ifdef MUXN_RR_PARITY_EN
    ,
    .y_par   (y_par)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [WIDTH-1:0] m_y;
  int               m_sel;
  logic             m_yv;
  int               m_ptr;
  logic [N-1:0]     exp_rdy, obs_rdy;

  function automatic logic [WIDTH-1:0] chan(input int i);
    return d[i*WIDTH +: WIDTH];
  endfunction

  // One clock cycle: settle, evaluate model, capture d_ready, advance.
  task automatic tick();
    int  g;
    bit  ok;
    bit  le;
    #1;
    le = !m_yv || y_ready;
    ok = 0;
    g  = 0;
    if (mode == 1'b0) begin
      g = int'(s);
      if (g < N) ok = d_valid[g];
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!ok && d_valid[c]) begin
          ok = 1;
          g  = c;
        end
      end
    end
    exp_rdy = (ok && le) ? N'(1 << g) : '0;
    obs_rdy = d_ready;
    @(posedge clk);
    if (reset) begin
      m_y = '0; m_sel = 0; m_yv = 0; m_ptr = N - 1;
    end else if (le) begin
      if (ok) begin
        m_y = chan(g); m_sel = g; m_yv = 1;
        if (mode) m_ptr = g;
      end else begin
        m_yv = 0;
      end
    end
    #1;
  endtask

  task automatic set_d(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c);
    d = {c, b, a};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; d_valid = '1; y_ready = 1'b1; mode = 1'b1; s = '0;
    set_d(8'h54, 8'h63, 8'h16);
    tick();
    reset = 1'b0;
    vectors++;
    if (y !== 8'h00 || y_sel !== 2'd0 || y_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: y=%h y_sel=%0d y_valid=%b required 00/0/0", y, y_sel, y_valid);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; s = 2'd2; d_valid = 3'b111; y_ready = 1'b1;
    set_d(8'h54, 8'h63, 8'h16);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_rdy !== 3'b100 || y !== 8'h16 || y_sel !== 2'd2 || y_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL fixed: d_ready=%b y=%h y_sel=%0d y_valid=%b required 100/16/2/1",
                 obs_rdy, y, y_sel, y_valid);
      end
    end
  endtask

  task automatic test_out_of_range();
    s = 2'd3;
    tick();
    vectors++;
    if (obs_rdy !== 3'b000 || y_valid !== 1'b0 || y !== 8'h16 || y_sel !== 2'd2) begin
      miscompares++;
      $display("FAIL s_oor: d_ready=%b y=%h y_sel=%0d y_valid=%b required 000/16/2/0",
               obs_rdy, y, y_sel, y_valid);
    end
  endtask

  task automatic test_rr();
    int             exp_sel [5];
    logic [WIDTH-1:0] exp_y [5];
    exp_sel = '{0, 1, 2, 0, 1};
    exp_y   = '{8'h54, 8'h63, 8'h16, 8'h54, 8'h63};
    do_reset();
    mode = 1'b1; d_valid = 3'b111; y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (y_sel !== SELW'(exp_sel[i]) || y !== exp_y[i] || y_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_seq[%0d]: y=%h y_sel=%0d required %h/%0d", i, y, y_sel,
                 exp_y[i], exp_sel[i]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    do_reset();
    mode = 1'b1; d_valid = 3'b101; y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (y_sel !== ((i % 2 == 0) ? 2'd0 : 2'd2) || obs_rdy[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL rr_sparse[%0d]: y_sel=%0d d_ready=%b required %0d", i, y_sel,
                 obs_rdy, (i % 2 == 0) ? 0 : 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_y;
    logic [SELW-1:0]  held_sel;
    mode = 1'b1; d_valid = 3'b111; y_ready = 1'b1;
    tick();
    held_y = y; held_sel = y_sel;
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (y !== held_y || y_sel !== held_sel || y_valid !== 1'b1 || obs_rdy !== 3'b000) begin
        miscompares++;
        $display("FAIL stall[%0d]: y=%h y_sel=%0d d_ready=%b required %h/%0d/000",
                 i, y, y_sel, obs_rdy, held_y, held_sel);
      end
    end
    y_ready = 1'b1;
    tick();
    vectors++;
    if (y_valid !== 1'b1 || y_sel !== SELW'(m_sel) || y !== m_y ||
        y_sel !== SELW'((int'(held_sel) + 1) % N) || obs_rdy === 3'b000) begin
      miscompares++;
      $display("FAIL release: y=%h y_sel=%0d y_valid=%b d_ready=%b required %h/%0d/1",
               y, y_sel, y_valid, obs_rdy, m_y, (int'(held_sel) + 1) % N);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; d_valid = 3'b111; y_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (y !== 8'h00 || y_valid !== 1'b0 || y_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid: y=%h y_valid=%b required 00/0", y, y_valid);
    end
    tick();
    vectors++;
    if (y_sel !== 2'd0 || y !== 8'h54 || y_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_grant: y=%h y_sel=%0d required 54/0", y, y_sel);
    end
`ifdef MUXN_RR_PARITY_EN
    vectors++;
    if (y_par !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_54: y_par=%b required 1", y_par);
    end
    tick();
    vectors++;
    if (y !== 8'h63 || y_par !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_63: y=%h y_par=%b required 63/0", y, y_par);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      d       = N*WIDTH'($urandom);
      d_valid = N'($urandom);
      mode    = 1'($urandom);
      s       = SELW'($urandom_range(0, 3));
      y_ready = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 49) == 0);
      tick();
      vectors++;
      if (obs_rdy !== exp_rdy || y !== m_y || y_sel !== SELW'(m_sel) || y_valid !== m_yv
`ifdef MUXN_RR_PARITY_EN
          || y_par !== ^m_y
`endif
         ) begin
        miscompares++;
        $display("FAIL random[%0d]: d_ready=%b y=%h y_sel=%0d y_valid=%b required %b/%h/%0d/%b",
                 i, obs_rdy, y, y_sel, y_valid, exp_rdy, m_y, m_sel, m_yv);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; d = '0; d_valid = '0; mode = 1'b0; s = '0; y_ready = 1'b0;
    m_y = '0; m_sel = 0; m_yv = 0; m_ptr = N - 1;
    @(posedge clk);
    #1;
    test_reset();
    test_fixed();
    test_out_of_range();
    test_rr();
    test_rr_sparse();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
